// File: rtl/sevenseg_scan_ctrl_if.sv
// CPU-side register bus of the seven-segment scan controller.
// The master drives writes and the read address; the slave returns registered read data.
interface sevenseg_scan_ctrl_if;
  logic        wr_en;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output wr_en, addr, wdata, input rdata);
  modport slave  (input wr_en, addr, wdata, output rdata);
endinterface

// File: rtl/sevenseg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode seven-segment display.
// CPU writes land in shadow registers, which are copied to the active set only at frame boundaries.
module sevenseg_scan_ctrl #(
  parameter int DIGITS      = 8,
  parameter int DEFAULT_DIV = 6250,
  parameter int DEAD_CYCLES = 500
) (
  input  logic                clk,
  input  logic                rst,
  sevenseg_scan_ctrl_if.slave bus,
  output logic [DIGITS-1:0]   o_an,
  output logic [6:0]          o_seg,
  output logic                o_frame_tick
);

  localparam int              IW         = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int              VW         = 4 * DIGITS;
  localparam logic [15:0]     DEAD_LEN   = 16'(DEAD_CYCLES);
  localparam logic [15:0]     MIN_DIV    = 16'(DEAD_CYCLES + 2);
  localparam logic [15:0]     RESET_DIV  = 16'(DEFAULT_DIV);
  localparam logic [IW-1:0]   LAST_DIGIT = IW'(DIGITS - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ON   = 2'd1;
  localparam logic [1:0] ST_DEAD = 2'd2;

  function automatic logic [6:0] hex_decode(input logic [3:0] nib);
    case (nib)
      4'h0: hex_decode = 7'b0000001;
      4'h1: hex_decode = 7'b1001111;
      4'h2: hex_decode = 7'b0010010;
      4'h3: hex_decode = 7'b0000110;
      4'h4: hex_decode = 7'b1001100;
      4'h5: hex_decode = 7'b0100100;
      4'h6: hex_decode = 7'b0100000;
      4'h7: hex_decode = 7'b0001111;
      4'h8: hex_decode = 7'b0000000;
      4'h9: hex_decode = 7'b0000100;
      4'hA: hex_decode = 7'b0001000;
      4'hB: hex_decode = 7'b1100000;
      4'hC: hex_decode = 7'b0110001;
      4'hD: hex_decode = 7'b1000010;
      4'hE: hex_decode = 7'b0110000;
      default: hex_decode = 7'b0111000;
    endcase
  endfunction

  logic [VW-1:0]     sh_value, act_value, nxt_sh_value, nxt_act_value;
  logic [DIGITS-1:0] sh_mask, act_mask, nxt_sh_mask, nxt_act_mask;
  logic [15:0]       sh_div, act_div, nxt_sh_div, nxt_act_div;
  logic              sh_en, act_en, nxt_sh_en, nxt_act_en;

  logic [1:0]        state, nxt_state;
  logic [IW-1:0]     digit, nxt_digit;
  logic [15:0]       cnt, nxt_cnt;
  logic [15:0]       div_eff, on_len;
  logic              load, kill;
  logic [DIGITS-1:0] an_d;
  logic [6:0]        seg_d;
  logic              tick_d;
  logic [31:0]       rdata_d;

  always_comb begin
    nxt_sh_value = sh_value;
    nxt_sh_mask  = sh_mask;
    nxt_sh_div   = sh_div;
    nxt_sh_en    = sh_en;
    if (bus.wr_en) begin
      case (bus.addr)
        2'd0:    nxt_sh_value = bus.wdata[VW-1:0];
        2'd1:    nxt_sh_mask  = bus.wdata[DIGITS-1:0];
        2'd2:    nxt_sh_div   = bus.wdata[15:0];
        default: nxt_sh_en    = bus.wdata[0];
      endcase
    end
  end

  // The clamp keeps at least two ON cycles per slot whatever the CPU programs.
  assign div_eff = (act_div < MIN_DIV) ? MIN_DIV : act_div;
  assign on_len  = div_eff - DEAD_LEN;
  assign kill    = bus.wr_en && (bus.addr == 2'd3) && !bus.wdata[0];

  always_comb begin
    nxt_state = state;
    nxt_digit = digit;
    nxt_cnt   = cnt;
    load      = 1'b0;
    case (state)
      ST_ON: begin
        if (cnt == on_len - 16'd1) begin
          nxt_state = ST_DEAD;
          nxt_cnt   = '0;
        end else begin
          nxt_cnt = cnt + 16'd1;
        end
      end
      ST_DEAD: begin
        if (cnt == DEAD_LEN - 16'd1) begin
          nxt_state = ST_ON;
          nxt_cnt   = '0;
          if (digit == LAST_DIGIT) begin
            nxt_digit = '0;
            load      = 1'b1;
          end else begin
            nxt_digit = digit + IW'(1);
          end
        end else begin
          nxt_cnt = cnt + 16'd1;
        end
      end
      default: begin
        if (act_en) begin
          nxt_state = ST_ON;
          nxt_digit = '0;
          nxt_cnt   = '0;
        end else begin
          load = 1'b1;
        end
      end
    endcase
    // Disabling is not deferred to the frame end: stop at once and resync the active set.
    if (kill) begin
      nxt_state = ST_IDLE;
      nxt_digit = '0;
      nxt_cnt   = '0;
      load      = 1'b1;
    end
  end

  assign nxt_act_value = load ? nxt_sh_value : act_value;
  assign nxt_act_mask  = load ? nxt_sh_mask  : act_mask;
  assign nxt_act_div   = load ? nxt_sh_div   : act_div;
  assign nxt_act_en    = load ? nxt_sh_en    : act_en;

  always_comb begin
    an_d  = '1;
    seg_d = 7'h7F;
    if (nxt_state == ST_ON) begin
      seg_d = hex_decode(nxt_act_value[{nxt_digit, 2'b00} +: 4]);
      if (nxt_act_mask[nxt_digit]) an_d[nxt_digit] = 1'b0;
    end
  end

  // The tick is high during the last blanking cycle of the final digit, i.e. the load cycle.
  assign tick_d = (nxt_state == ST_DEAD) && (nxt_cnt == DEAD_LEN - 16'd1) &&
                  (nxt_digit == LAST_DIGIT);

  always_comb begin
    case (bus.addr)
      2'd0:    rdata_d = 32'(sh_value);
      2'd1:    rdata_d = 32'(sh_mask);
      2'd2:    rdata_d = {16'h0000, sh_div};
      default: rdata_d = {31'h0, sh_en};
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_value     <= '0;
      sh_mask      <= '1;
      sh_div       <= RESET_DIV;
      sh_en        <= 1'b0;
      act_value    <= '0;
      act_mask     <= '1;
      act_div      <= RESET_DIV;
      act_en       <= 1'b0;
      state        <= ST_IDLE;
      digit        <= '0;
      cnt          <= '0;
      o_an         <= '1;
      o_seg        <= 7'h7F;
      o_frame_tick <= 1'b0;
      bus.rdata    <= '0;
    end else begin
      sh_value     <= nxt_sh_value;
      sh_mask      <= nxt_sh_mask;
      sh_div       <= nxt_sh_div;
      sh_en        <= nxt_sh_en;
      act_value    <= nxt_act_value;
      act_mask     <= nxt_act_mask;
      act_div      <= nxt_act_div;
      act_en       <= nxt_act_en;
      state        <= nxt_state;
      digit        <= nxt_digit;
      cnt          <= nxt_cnt;
      o_an         <= an_d;
      o_seg        <= seg_d;
      o_frame_tick <= tick_d;
      bus.rdata    <= rdata_d;
    end
  end

endmodule

// File: doc/sevenseg_scan_ctrl.md
Name: sevenseg_scan_ctrl

Overview:
Time-multiplexed scan controller for the board's 8-digit common-anode seven-segment display (AN, CA..CG).
- Holds a CPU-writable shadow register set (digit nibbles, digit enable mask, scan divider, control).
- Copies shadow to active registers only at frame boundaries, so displayed digits never tear.
- Sequences anodes with a blanking dead time between digits to suppress ghosting.
- Sits inside the core's peripheral space, in the core clock domain.

Parameters:
DIGITS, 8, number of digits scanned (value register holds DIGITS nibbles)
DEFAULT_DIV, 6250, reset value of the scan divider in clk cycles per digit slot (50 MHz -> 1 kHz frame)
DEAD_CYCLES, 500, blanking cycles at the end of every digit slot

Ports:
clk  in  1  core clock; sole clock
rst  in  1  asynchronous, active-high reset
i_wr_en  in  1  write strobe, one transfer per cycle
i_addr  in  2  register select: 0 value, 1 mask, 2 divider, 3 control; also the read address
i_wdata  in  32  write data
o_rdata  out  32  shadow register at i_addr, registered, 1-cycle latency
o_an  out  DIGITS  anode enables, active-low
o_seg  out  7  {CA,CB,CC,CD,CE,CF,CG}, active-low
o_frame_tick  out  1  one-cycle pulse on each shadow->active load

Behaviour:
Reset values:
- Shadow and active registers: value=0, mask=8'hFF, div=DEFAULT_DIV, ctrl.en=0.
- State IDLE, digit index 0, slot counter 0.
- Outputs: o_an=all 1, o_seg=7'h7F, o_rdata=0, o_frame_tick=0.

Registers:
- value[4i+3:4i] is digit i.
- mask[i]=1 enables digit i.
- div uses [15:0]; the other bits read 0.
- ctrl bit0 = en; the other bits read 0.

Divider clamp: effective div = max(div, DEAD_CYCLES+2). This guarantees at least 2 ON cycles per slot.

States:
- IDLE: all outputs off. While en=0, shadow copies to active every cycle. When active en=1, go to ON with digit=0 and counter=0.
- ON: drive digit. Lasts div-DEAD_CYCLES cycles, then go to DEAD.
- DEAD: o_an all 1, o_seg 7'h7F. Lasts DEAD_CYCLES cycles. Then digit=(digit+1) mod DIGITS and go to ON.

Frame load:
- Occurs in the last DEAD cycle of digit DIGITS-1: all shadow registers copy to active and o_frame_tick=1.
- A write landing in that same cycle is included in the load (load takes post-write shadow).

Outputs (registered, updated on the same edge as the state):
- In ON, o_an has bit digit low only if mask[digit]=1. A masked digit still consumes its slot, so refresh rate is constant.
- o_seg is the hex decode of the active nibble:
  0:0000001 1:1001111 2:0010010 3:0000110 4:1001100 5:0100100 6:0100000 7:0001111
  8:0000000 9:0000100 A:0001000 b:1100000 C:0110001 d:1000010 E:0110000 F:0111000

Disable and enable timing:
- Writing ctrl.en=0 while running takes effect immediately, not at frame end. The next edge returns to IDLE with outputs off and digit/counter cleared.
- Writing ctrl.en=1 from IDLE: the write edge E0 updates shadow and active. At E1 the state is ON, digit 0, o_an=~8'h01.

Reset asserted mid-scan: outputs go to reset values asynchronously. Shadow writes are discarded.

Writes during scan affect shadow only (except ctrl.en=0 as above). o_rdata always shows shadow.

Test Plan:
- Reset -> o_an=8'hFF, o_seg=7'h7F, o_frame_tick=0; read addr 1 -> 0x000000FF; read addr 2 -> 6250.
- Write value=0x89ABCDEF, div=1000, DEAD_CYCLES=500, en=1 -> o_an=8'hFE with o_seg=0111000 (F) for 500 cycles, then blank for 500, then 8'hFD with 0110000 (E); o_frame_tick every 8000 cycles.
- Mid-frame write value=0x0 while digit 3 is shown -> digits 3..7 still show the old nibbles; after o_frame_tick, digit 0 shows 0000001.
- Write mask=8'h0F -> slots 4..7 keep o_an=8'hFF for their full 1000 cycles each; frame period unchanged at 8000.
- Write div=10 (below clamp) -> effective slot is 502 cycles: 2 ON + 500 DEAD.
- Write ctrl=0 during ON of digit 5 -> next cycle o_an=8'hFF; re-enable -> scan restarts at digit 0. Assert rst mid-DEAD -> immediate reset values.
